// File: rtl/conv_pkg.sv
// Shared types and default dimensions for the first convolution stage.
// Holds the frame sequencer state encoding and default image/kernel geometry.
package conv_pkg;

  localparam int CONV_FILTERS = 6;
  localparam int IMG_W_DEF    = 32;
  localparam int IMG_H_DEF    = 32;
  localparam int KERNEL_DEF   = 5;
  localparam int TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pix_pos_counter.sv
// Row/column raster position counter: advances one pixel per inc, wraps at the frame end.
// Position updates on the edge after inc; last is combinational from the current position.
module pix_pos_counter #(
  parameter int W = 32,
  parameter int H = 32,
  localparam int CW = $clog2(W),
  localparam int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame controller: admits IMG_W*IMG_H pixels, then waits for all conv outputs and pulses done.
// Pixel accept is zero-latency and drops ready in the same cycle i_buffer_full rises.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int KERNEL  = KERNEL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int OUT_TOTAL = (IMG_W - KERNEL + 1) * (IMG_H - KERNEL + 1),
  localparam int RW  = $clog2(IMG_H),
  localparam int CW  = $clog2(IMG_W),
  localparam int OCW = $clog2(OUT_TOTAL + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic           i_pix_valid,
  output logic           o_pix_ready,
  input  logic           i_buffer_full,
  output logic           o_conv_valid,
  input  logic           i_conv_out_valid,
  output logic [RW-1:0]  o_row,
  output logic [CW-1:0]  o_col,
  output logic [OCW-1:0] o_out_count,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [OCW-1:0] OUT_MAX  = OCW'(OUT_TOTAL);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  seq_state_t     state;
  logic [OCW-1:0] out_count;
  logic [TW-1:0]  idle_cnt;
  logic           err;
  logic           pos_last;
  logic           counting;
  logic           stray;
  logic [OCW-1:0] count_nxt;

  assign o_pix_ready  = (state == LOAD) && !i_buffer_full;
  assign o_conv_valid = o_pix_ready && i_pix_valid;

  // Outputs are only legal while a frame is open and not yet complete.
  assign counting  = i_conv_out_valid && ((state == LOAD) || (state == DRAIN))
                     && (out_count != OUT_MAX);
  assign stray     = i_conv_out_valid && !counting;
  assign count_nxt = out_count + OCW'(counting);

  pix_pos_counter #(
    .W (IMG_W),
    .H (IMG_H)
  ) u_pos (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state == IDLE) && i_start),
    .inc  (o_conv_valid),
    .row  (o_row),
    .col  (o_col),
    .last (pos_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_count <= '0;
      idle_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= LOAD;
            out_count <= '0;
            idle_cnt  <= '0;
            err       <= 1'b0;
          end else if (stray) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          out_count <= count_nxt;
          idle_cnt  <= '0;
          if (stray) err <= 1'b1;
          if (o_conv_valid && pos_last) state <= DRAIN;
        end
        DRAIN: begin
          out_count <= count_nxt;
          if (stray) err <= 1'b1;
          if (count_nxt == OUT_MAX) begin
            state <= DONE;
          end else if (i_conv_out_valid) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TMO_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        DONE: begin
          if (stray) err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_out_count = out_count;
  assign o_busy      = (state == LOAD) || (state == DRAIN);
  assign o_done      = (state == DONE);
  assign o_err       = err;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Scoreboard bench for conv_frame_sequencer on a 6x6 frame, 3x3 kernel, timeout 8.
// Stimulus pushes expected accept positions and done records; a monitor pops and compares.
module tb_conv_frame_sequencer;

  localparam int IMG_W = 6;
  localparam int IMG_H = 6;
  localparam int KERNEL = 3;
  localparam int TIMEOUT = 8;
  localparam int NPIX = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_pix_valid = 1'b0;
  logic       i_buffer_full = 1'b0;
  logic       i_conv_out_valid = 1'b0;
  logic       o_pix_ready;
  logic       o_conv_valid;
  logic [2:0] o_row;
  logic [2:0] o_col;
  logic [4:0] o_out_count;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int pos_q[$];
  int done_q[$];

  conv_frame_sequencer #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .KERNEL  (KERNEL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_pix_valid      (i_pix_valid),
    .o_pix_ready      (o_pix_ready),
    .i_buffer_full    (i_buffer_full),
    .o_conv_valid     (o_conv_valid),
    .i_conv_out_valid (i_conv_out_valid),
    .o_row            (o_row),
    .o_col            (o_col),
    .o_out_count      (o_out_count),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accept must match the next expected raster position; every done the next record.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_conv_valid) begin
        if (i_buffer_full) chk("conv_valid_while_full", 1, 0);
        if (pos_q.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          int p;
          p = pos_q.pop_front();
          chk("accept_row", 32'(o_row), p / 16);
          chk("accept_col", 32'(o_col), p % 16);
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          int d;
          d = done_q.pop_front();
          chk("done_out_count", 32'(o_out_count), d / 2);
          chk("done_err", 32'(o_err), d % 2);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: bp throttles every third cycle, outputs fire on accepts with index in
  // [out_lo, out_lo+n_load), then n_drain spaced outputs; abort_at>0 resets after that many accepts.
  task automatic run_frame(input string name, input bit bp, input int out_lo, input int n_load,
                           input int n_drain, input bit noise, input int abort_at,
                           input int exp_cnt, input bit exp_err, input int exp_lat);
    int acc, c, er, ec, last_edge, d0, waited;
    bit take;
    d0 = done_cnt;
    acc = 0; c = 0; er = 0; ec = 0; last_edge = 0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk({name, "_start_busy"}, 32'(o_busy), 1);
    chk({name, "_start_err"}, 32'(o_err), 0);
    chk({name, "_start_count"}, 32'(o_out_count), 0);
    chk({name, "_start_pos"}, 32'({o_row, o_col}), 0);
    if (abort_at == 0) done_q.push_back(exp_cnt * 2 + int'(exp_err));
    while (acc < NPIX && !(abort_at > 0 && acc == abort_at) && c < 400) begin
      take = !(bp && (c % 3 == 2));
      i_buffer_full    = !take;
      i_pix_valid      = 1'b1;
      i_conv_out_valid = take && acc >= out_lo && acc < out_lo + n_load;
      i_start          = noise && c == 5;
      if (take) begin
        pos_q.push_back(er * 16 + ec);
        if (ec == IMG_W - 1) begin
          ec = 0;
          er = (er == IMG_H - 1) ? 0 : er + 1;
        end else begin
          ec++;
        end
      end
      tick();
      if (take) begin
        acc++;
        last_edge = cyc;
      end
      c++;
    end
    i_buffer_full = 1'b0;
    i_conv_out_valid = 1'b0;
    i_start = 1'b0;
    if (abort_at > 0) begin
      chk({name, "_count_before_rst"}, 32'(o_out_count), exp_cnt);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk({name, "_rst_busy"}, 32'(o_busy), 0);
      chk({name, "_rst_ready"}, 32'(o_pix_ready), 0);
      chk({name, "_rst_conv_valid"}, 32'(o_conv_valid), 0);
      chk({name, "_rst_pos"}, 32'({o_row, o_col}), 0);
      chk({name, "_rst_count"}, 32'(o_out_count), 0);
      chk({name, "_rst_err_done"}, 32'({o_err, o_done}), 0);
      i_pix_valid = 1'b0;
      pos_q.delete();
      return;
    end
    for (int k = 0; k < n_drain; k++) begin
      i_conv_out_valid = 1'b1;
      i_start = noise && k == 0;
      tick();
      last_edge = cyc;
      i_conv_out_valid = 1'b0;
      i_start = 1'b0;
      if (k < n_drain - 1) tick();
    end
    waited = 0;
    while (done_cnt == d0 && waited < 30) begin
      tick();
      waited++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt - d0), 1);
    chk({name, "_done_latency"}, 32'(done_cyc - last_edge), exp_lat);
    i_pix_valid = 1'b0;
    repeat (3) tick();
    chk({name, "_single_done"}, 32'(done_cnt - d0), 1);
    chk({name, "_err_held"}, 32'(o_err), exp_err);
    chk({name, "_idle_pos"}, 32'({o_row, o_col}), 0);
    chk({name, "_idle_busy"}, 32'(o_busy), 0);
    chk({name, "_accepts_left"}, 32'(pos_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_pix_valid = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", 32'({o_pix_ready, o_conv_valid, o_busy, o_done, o_err}), 0);
    chk("reset_pos", 32'({o_row, o_col}), 0);
    chk("reset_count", 32'(o_out_count), 0);
    rst = 1'b0;
    tick();
    chk("idle_no_ready", 32'(o_pix_ready), 0);
    i_pix_valid = 1'b0;

    run_frame("nominal",       1'b0, 20, 16, 0, 1'b0, 0,  16, 1'b0, 1);
    run_frame("backpressure",  1'b1, 20, 16, 0, 1'b0, 0,  16, 1'b0, 1);
    run_frame("timeout",       1'b0,  0, 10, 0, 1'b0, 0,  10, 1'b1, 8);

    // Stray output in IDLE after an errored frame must leave err set and count untouched.
    i_conv_out_valid = 1'b1;
    tick();
    i_conv_out_valid = 1'b0;
    chk("stray_err", 32'(o_err), 1);
    chk("stray_count", 32'(o_out_count), 10);
    run_frame("start_noise",   1'b0, 20,  8, 8, 1'b1, 0,  16, 1'b0, 0);
    i_conv_out_valid = 1'b1;
    tick();
    i_conv_out_valid = 1'b0;
    chk("stray2_err", 32'(o_err), 1);
    chk("stray2_count", 32'(o_out_count), 16);

    run_frame("full_on_entry", 1'b1, 10, 16, 0, 1'b0, 0,  16, 1'b0, 1);
    run_frame("abort",         1'b0, 10, 16, 0, 1'b0, 20, 10, 1'b0, 0);
    chk("post_abort_stray_clear", 32'(o_err), 0);
    i_conv_out_valid = 1'b1;
    tick();
    i_conv_out_valid = 1'b0;
    chk("idle_stray_err", 32'(o_err), 1);
    chk("idle_stray_count", 32'(o_out_count), 0);
    run_frame("after_reset",   1'b1, 20, 16, 0, 1'b0, 0,  16, 1'b0, 1);

    chk("done_queue_empty", 32'(done_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
